// File: rtl/iob_cache_line_fetch_pkg.sv
// Shared definitions for the cache line refill engine: FSM state encoding
// and the derived byte-offset width of a back-end word.
package iob_cache_line_fetch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic int be_nbytes_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/iob_cache_wrap_cnt.sv
// Beat counter for a line refill. widx is the word index of the current beat,
// wrapping modulo the line size around base when CWF is set.
module iob_cache_wrap_cnt #(
  parameter int LINE2BE_W = 2,
  parameter int CWF       = 1,
  localparam int CW       = (LINE2BE_W > 0) ? LINE2BE_W : 1
) (
  input  logic          clk_i,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] base,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] widx,
  output logic          last
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          unused_base;

  assign unused_base = ^base;
  assign cnt  = cnt_q;
  assign last = (LINE2BE_W == 0) || (cnt_q == {CW{1'b1}});

  // The counter stops on the last beat; the next request clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // CW-bit add: the carry is dropped so the index never leaves the line.
  always_comb begin
    widx = '0;
    if (LINE2BE_W > 0) begin
      widx = (CWF != 0) ? (base + cnt_q) : cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/iob_cache_line_fetch.sv
// Line refill engine: fetches one cache line from the back end, one word per
// handshake, and streams each word into the line data memory.
module iob_cache_line_fetch
  import iob_cache_line_fetch_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int BE_ADDR_W = 32,
  parameter int BE_DATA_W = 32,
  parameter int LINE2BE_W = 2,
  parameter int CWF       = 1,
  localparam int NB       = be_nbytes_w(BE_DATA_W),
  localparam int AW       = ADDR_W - NB,
  localparam int CW       = (LINE2BE_W > 0) ? LINE2BE_W : 1
) (
  input  logic                 clk_i,
  input  logic                 reset,
  input  logic                 replace_valid,
  input  logic [AW-1:0]        replace_addr,
  output logic                 replace,
  output logic                 read_valid,
  output logic [CW-1:0]        read_addr,
  output logic [BE_DATA_W-1:0] read_rdata,
  output logic                 crit_valid,
  output logic                 done,
  output logic [BE_ADDR_W-1:0] be_addr,
  output logic                 be_valid,
  input  logic                 be_ready,
  input  logic [BE_DATA_W-1:0] be_rdata,
  output logic [1:0]           state_dbg
);

  // Handshake: a beat moves on a cycle where be_valid & be_ready are both high;
  // be_valid stays high with a stable be_addr until that happens, and each
  // accepted beat is written to the line memory in the same cycle.

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          cnt_clr, cnt_inc, cnt_last;
  logic [CW-1:0] cnt, widx, word_off;
  logic [AW-1:0] word_addr;
  logic          fetch;

  iob_cache_wrap_cnt #(
    .LINE2BE_W(LINE2BE_W),
    .CWF      (CWF)
  ) u_wrap_cnt (
    .clk_i(clk_i),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .base (word_off),
    .cnt  (cnt),
    .widx (widx),
    .last (cnt_last)
  );

  generate
    if (LINE2BE_W > 0) begin : g_multi
      assign word_off  = addr_q[CW-1:0];
      assign word_addr = {addr_q[AW-1:LINE2BE_W], widx};
    end else begin : g_single
      assign word_off  = '0;
      assign word_addr = addr_q;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (replace_valid) begin
          addr_d  = replace_addr;
          cnt_clr = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (be_ready) begin
          cnt_inc = 1'b1;
          if (cnt_last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  assign fetch      = (state_q == ST_FETCH);
  assign replace    = (state_q != ST_IDLE);
  assign be_valid   = fetch;
  assign done       = (state_q == ST_DONE);
  assign read_valid = fetch && be_ready;
  assign read_addr  = fetch ? widx : '0;
  assign read_rdata = be_rdata;
  assign crit_valid = read_valid && (widx == word_off);
  // Outside FETCH the address is parked at zero rather than the stale line.
  assign be_addr    = fetch ? (BE_ADDR_W'(word_addr) << NB) : '0;
  assign state_dbg  = state_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule
